// File: rtl/ic_fetch_buffer.sv
// ic_fetch_buffer
//   Fetch-side line buffer between PC/redirect logic and the L1 instruction
//   cache. It requests one cache line at a time on the cache's req/ack port.
//   It holds the returned line and hands out sequential 32-bit instructions,
//   with their PC, to decode. Redirects are absorbed without ever dropping
//   ic_req before the cache has acked the request in flight.
//
//   Optional feature: define ICFB_PERF_EN to add the perf_lines and
//   perf_redirects counters and their output ports.
//
// Ports
//   clk_in, reset_in      clock; synchronous active-high reset
//   redirect_valid/_pc    one-cycle restart request and its target PC
//   ic_req, ic_addr       line request and line-aligned address to the cache
//   ic_ack, ic_ack_data,  line delivered (data, fault flag); may arrive in
//   ic_ack_fault          the same cycle as ic_req
//   instr_valid, instr,   instruction word, its PC and fault flag to decode
//   instr_pc, instr_fault
//   instr_rdy             decode accepts
//   dbg_state             current FSM state (FB_FETCH/FB_DISCARD/FB_SERVE)
//   perf_lines            (ICFB_PERF_EN) lines accepted into FB_SERVE
//   perf_redirects        (ICFB_PERF_EN) redirect pulses seen
//
// Handshakes
//   Decode side: a word moves when instr_valid & instr_rdy are both high at
//   posedge. instr_valid never depends on instr_rdy. Cache side: ic_req,
//   once raised, stays high with a stable ic_addr until the cycle ic_ack
//   is high. ic_req is decoded from registers only.

module ic_fetch_buffer #(
    parameter int          A_SZ     = 32,
    parameter int          CL_LEN   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  redirect_valid,
    input  logic [A_SZ-1:0]       redirect_pc,
    output logic                  ic_req,
    output logic [A_SZ-1:0]       ic_addr,
    input  logic                  ic_ack,
    input  logic [CL_LEN*8-1:0]   ic_ack_data,
    input  logic                  ic_ack_fault,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [A_SZ-1:0]       instr_pc,
    output logic                  instr_fault,
    input  logic                  instr_rdy,
`ifdef ICFB_PERF_EN
    output logic [31:0]           perf_lines,
    output logic [31:0]           perf_redirects,
`endif
    output logic [1:0]            dbg_state
);

    localparam int CL_SZ = $clog2(CL_LEN);
    localparam int WPL   = CL_LEN / 4;
    localparam int WI    = CL_SZ - 2;     // word-index width inside a line
    localparam int LA    = A_SZ - CL_SZ;  // line-address width

    localparam logic [1:0] FB_FETCH   = 2'd0;
    localparam logic [1:0] FB_DISCARD = 2'd1;
    localparam logic [1:0] FB_SERVE   = 2'd2;

    localparam logic [WI-1:0]   LAST_WORD = WI'(WPL - 1);
    localparam logic [A_SZ-1:0] PC_STEP   = A_SZ'(4);
    localparam logic [LA-1:0]   LINE_STEP = LA'(1);
    localparam logic [A_SZ-1:0] RST_PC    = {RESET_PC[A_SZ-1:2], 2'b00};

    logic [1:0]          state;
    logic [A_SZ-1:0]     pc;
    logic [LA-1:0]       line_addr;
    logic [LA-1:0]       pend_line;   // line still owed by the cache after a redirect
    logic [CL_LEN*8-1:0] line;
    logic                line_fault;
    logic                req_armed;   // low for the cycle right after reset

    logic [WI-1:0]       word_idx;
    logic [A_SZ-1:0]     redir_pc_al;
    logic [LA-1:0]       redir_line;
    logic                xfer;

    assign word_idx    = pc[CL_SZ-1:2];
    assign redir_pc_al = {redirect_pc[A_SZ-1:2], 2'b00};
    assign redir_line  = redirect_pc[A_SZ-1:CL_SZ];

    // A redirect kills the current word so it can never be transferred
    // alongside the restart.
    assign instr_valid = (state == FB_SERVE) && !redirect_valid;
    assign xfer        = instr_valid && instr_rdy;

    assign instr       = line[word_idx*32 +: 32];
    assign instr_pc    = pc;
    assign instr_fault = line_fault;

    assign ic_req  = req_armed && ((state == FB_FETCH) || (state == FB_DISCARD));
    assign ic_addr = (state == FB_DISCARD) ? {pend_line, {CL_SZ{1'b0}}}
                                           : {line_addr, {CL_SZ{1'b0}}};

    assign dbg_state = state;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state      <= FB_FETCH;
            pc         <= RST_PC;
            line_addr  <= RST_PC[A_SZ-1:CL_SZ];
            pend_line  <= '0;
            line       <= '0;
            line_fault <= 1'b0;
            req_armed  <= 1'b0;
        end else begin
            req_armed <= 1'b1;
            case (state)
                FB_FETCH: begin
                    // Only an accepted request may move the FSM.
                    if (req_armed) begin
                        if (redirect_valid) begin
                            pc        <= redir_pc_al;
                            line_addr <= redir_line;
                            if (!ic_ack) begin
                                // Cache still owes us the old line: keep
                                // presenting it until it is acked.
                                pend_line <= line_addr;
                                state     <= FB_DISCARD;
                            end
                        end else if (ic_ack) begin
                            line       <= ic_ack_data;
                            line_fault <= ic_ack_fault;
                            state      <= FB_SERVE;
                        end
                    end
                end
                FB_DISCARD: begin
                    if (redirect_valid) begin
                        pc        <= redir_pc_al;
                        line_addr <= redir_line;
                    end
                    if (ic_ack) begin
                        state <= FB_FETCH;
                    end
                end
                FB_SERVE: begin
                    if (redirect_valid) begin
                        pc <= redir_pc_al;
                        if (redir_line != line_addr) begin
                            line_addr <= redir_line;
                            state     <= FB_FETCH;
                        end
                    end else if (xfer) begin
                        pc <= pc + PC_STEP;
                        if (word_idx == LAST_WORD) begin
                            line_addr <= line_addr + LINE_STEP;
                            state     <= FB_FETCH;
                        end
                    end
                end
                default: begin
                    state <= FB_FETCH;
                end
            endcase
        end
    end

`ifdef ICFB_PERF_EN
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            perf_lines     <= '0;
            perf_redirects <= '0;
        end else begin
            if (req_armed && (state == FB_FETCH) && ic_ack && !redirect_valid) begin
                perf_lines <= perf_lines + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ic_fetch_buffer.sv
// Directed testbench for ic_fetch_buffer (RESET_PC = 0x100, 32-byte lines).
// Inputs are driven and outputs sampled around the falling edge; the DUT
// updates on the rising edge. Line data for base B has word k equal to
// 32'hA500_0000 | (B + 4k), so the expected instr for a PC p is
// 32'hA500_0000 | p.

module tb_ic_fetch_buffer;

    localparam int A_SZ   = 32;
    localparam int CL_LEN = 32;

    logic              clk_in;
    logic              reset_in;
    logic              redirect_valid;
    logic [A_SZ-1:0]   redirect_pc;
    logic              ic_req;
    logic [A_SZ-1:0]   ic_addr;
    logic              ic_ack;
    logic [CL_LEN*8-1:0] ic_ack_data;
    logic              ic_ack_fault;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [A_SZ-1:0]   instr_pc;
    logic              instr_fault;
    logic              instr_rdy;
    logic [1:0]        dbg_state;
`ifdef ICFB_PERF_EN
    logic [31:0]       perf_lines;
    logic [31:0]       perf_redirects;
`endif

    int tests_run;
    int tests_failed;

    ic_fetch_buffer #(
        .A_SZ(A_SZ), .CL_LEN(CL_LEN), .RESET_PC(32'h100)
    ) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_ack(ic_ack), .ic_ack_data(ic_ack_data), .ic_ack_fault(ic_ack_fault),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_fault(instr_fault), .instr_rdy(instr_rdy),
`ifdef ICFB_PERF_EN
        .perf_lines(perf_lines), .perf_redirects(perf_redirects),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // checking
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver helpers
    task automatic cyc();
        @(negedge clk_in);
    endtask

    function automatic logic [CL_LEN*8-1:0] mk_line(input logic [31:0] base);
        logic [CL_LEN*8-1:0] l;
        l = '0;
        for (int k = 0; k < CL_LEN/4; k++) begin
            l[k*32 +: 32] = 32'hA500_0000 | (base + 32'(k*4));
        end
        return l;
    endfunction

    // Hand a line back on the current cycle, then drop ack.
    task automatic ack_line(input logic [31:0] base, input logic fault);
        ic_ack       = 1'b1;
        ic_ack_data  = mk_line(base);
        ic_ack_fault = fault;
        cyc();
        ic_ack       = 1'b0;
        ic_ack_fault = 1'b0;
    endtask

    // Expect n consecutive words from start_pc with instr_rdy held high.
    task automatic serve_words(input string tag, input logic [31:0] start_pc,
                               input int n, input logic fault);
        logic [31:0] p;
        p = start_pc;
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_valid"}, 64'(instr_valid), 64'd1);
            check({tag, "_pc"},    64'(instr_pc),    64'(p));
            check({tag, "_instr"}, 64'(instr),       64'(32'hA500_0000 | p));
            check({tag, "_fault"}, 64'(instr_fault), 64'(fault));
            cyc();
            p = p + 32'd4;
        end
    endtask

    initial begin
        reset_in       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ic_ack         = 1'b0;
        ic_ack_data    = '0;
        ic_ack_fault   = 1'b0;
        instr_rdy      = 1'b0;
        tests_run      = 0;
        tests_failed   = 0;

        // reset state
        cyc(); cyc();
        #1;
        check("rst_req",   64'(ic_req),      64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_fault", 64'(instr_fault), 64'd0);
        check("rst_state", 64'(dbg_state),   64'd0);
`ifdef ICFB_PERF_EN
        check("rst_perf_lines", 64'(perf_lines),     64'd0);
        check("rst_perf_redir", 64'(perf_redirects), 64'd0);
`endif
        reset_in = 1'b0;
        cyc();

        // first line, hit in the same cycle as the request
        #1;
        check("t1_req",   64'(ic_req),      64'd1);
        check("t1_addr",  64'(ic_addr),     64'h100);
        check("t1_valid", 64'(instr_valid), 64'd0);
        instr_rdy = 1'b1;
        ack_line(32'h100, 1'b0);
        serve_words("t1", 32'h100, 8, 1'b0);
        #1;
        check("t1_next_req",   64'(ic_req),      64'd1);
        check("t1_next_addr",  64'(ic_addr),     64'h120);
        check("t1_next_valid", 64'(instr_valid), 64'd0);

        // ready toggling: held word, no skip or repeat
        ack_line(32'h120, 1'b0);
        serve_words("t2a", 32'h120, 1, 1'b0);
        instr_rdy = 1'b0;
        #1;
        check("t2_hold0_pc", 64'(instr_pc), 64'h124);
        cyc();
        #1;
        check("t2_hold1_pc",    64'(instr_pc), 64'h124);
        check("t2_hold1_instr", 64'(instr),    64'hA500_0124);
        check("t2_hold1_valid", 64'(instr_valid), 64'd1);
        instr_rdy = 1'b1;
        cyc();
        serve_words("t2b", 32'h128, 1, 1'b0);

        // same-line redirect together with ready: no transfer, no refetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h136;   // low bits ignored -> 0x134
        #1;
        check("t4_kill_valid", 64'(instr_valid), 64'd0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t4_req", 64'(ic_req), 64'd0);
        serve_words("t4", 32'h134, 3, 1'b0);
        #1;
        check("t4_next_addr", 64'(ic_addr), 64'h140);

        // redirect while a request is pending for three cycles
        redirect_valid = 1'b1;
        redirect_pc    = 32'h208;
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_pend_req",   64'(ic_req),      64'd1);
            check("t3_pend_addr",  64'(ic_addr),     64'h140);
            check("t3_pend_valid", 64'(instr_valid), 64'd0);
            if (i < 2) cyc();
        end
        ack_line(32'h140, 1'b0);    // stale data, must be dropped
        #1;
        check("t3_new_req",   64'(ic_req),      64'd1);
        check("t3_new_addr",  64'(ic_addr),     64'h200);
        check("t3_new_valid", 64'(instr_valid), 64'd0);
        ack_line(32'h200, 1'b0);
        serve_words("t3", 32'h208, 1, 1'b0);

        // other-line redirect while serving, then a faulted line
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t5_req",  64'(ic_req),  64'd1);
        check("t5_addr", 64'(ic_addr), 64'h300);
        ack_line(32'h300, 1'b1);
        serve_words("t5", 32'h300, 8, 1'b1);
        #1;
        check("t5_next_addr", 64'(ic_addr), 64'h320);

        // redirect in the same cycle as the ack: data dropped, refetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h404;
        ack_line(32'h320, 1'b0);
        redirect_valid = 1'b0;
        #1;
        check("t6_req",   64'(ic_req),      64'd1);
        check("t6_addr",  64'(ic_addr),     64'h400);
        check("t6_valid", 64'(instr_valid), 64'd0);
        ack_line(32'h400, 1'b0);
        serve_words("t6", 32'h404, 1, 1'b0);

        // leave a request outstanding, then reset over it
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t7_addr", 64'(ic_addr), 64'h500);
`ifdef ICFB_PERF_EN
        check("perf_lines", 64'(perf_lines),     64'd5);
        check("perf_redir", 64'(perf_redirects), 64'd5);
`endif
        reset_in = 1'b1;
        cyc();
        #1;
        check("t7_rst_req",   64'(ic_req),      64'd0);
        check("t7_rst_valid", 64'(instr_valid), 64'd0);
        check("t7_rst_state", 64'(dbg_state),   64'd0);
        reset_in = 1'b0;
        cyc();
        #1;
        check("t7_req",      64'(ic_req),  64'd1);
        check("t7_addr_100", 64'(ic_addr), 64'h100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
